// File: rtl/prefetch_stage.sv
// Instruction prefetch stage: single-outstanding memory fetch FSM feeding a
// DEPTH-entry FIFO of {instruction, fetch address} pairs with branch redirect.
module prefetch_stage #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned INSTR_W  = 64,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               halt,
   input  logic               branch,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_address,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_read_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  instr_pc
);

   localparam int unsigned       PTR_W  = $clog2(DEPTH);
   localparam int unsigned       CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   tag_q;
   logic                discard_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic                pop;
   logic                push;
   logic                issue_ok;

   logic [INSTR_W-1:0]  data_mem [DEPTH];
   logic [ADDR_W-1:0]   addr_mem [DEPTH];

   // NOTE: every signal is assigned on every pass through always_comb, so no latch is inferred.
   always_comb begin
      pop      = (count_q != '0) && instr_ready;
      push     = (state_q == S_WAIT) && mem_rvalid && !discard_q && !branch;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      issue_ok = !halt && (count_d < FULL);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= PC_RST;
         tag_q     <= '0;
         discard_q <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else if (branch) begin
         // Redirect wins over grant, response and pop in the same cycle.
         pc_q     <= branch_target;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         unique case (state_q)
            S_REQ: begin
               if (mem_gnt) begin
                  state_q   <= S_WAIT;
                  discard_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  state_q   <= halt ? S_IDLE : S_REQ;
                  discard_q <= 1'b0;
               end else begin
                  discard_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end else begin
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         count_q <= count_d;
         unique case (state_q)
            S_IDLE: begin
               if (!halt && (count_q < FULL)) state_q <= S_REQ;
            end
            S_REQ: begin
               if (mem_gnt) begin
                  state_q <= S_WAIT;
                  pc_q    <= pc_q + PC_INC;
                  tag_q   <= pc_q;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  state_q   <= issue_ok ? S_REQ : S_IDLE;
                  discard_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: the storage array is not reset; entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= mem_read_data;
         addr_mem[wr_ptr_q] <= tag_q;
      end
   end

   assign mem_req     = (state_q == S_REQ);
   assign mem_address = pc_q;
   assign instr_valid = (count_q != '0);
   assign instruction = instr_valid ? data_mem[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? addr_mem[rd_ptr_q] : '0;

endmodule

// File: doc/prefetch_stage.md
PREFETCH_STAGE -- requirements
Module: prefetch_stage

Interface
REQ-001 Parameter ADDR_W, 8, PC and memory address width in bits.
REQ-002 Parameter INSTR_W, 64, instruction word width in bits.
REQ-003 Parameter DEPTH, 4, prefetch buffer entries; power of two, >= 2.
REQ-004 Parameter PC_STEP, 4, PC increment per fetched word.
REQ-005 Parameter RESET_PC, 0, PC value loaded at reset.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 halt  in  1  blocks issue of new memory requests.
REQ-009 branch  in  1  redirect: flush the buffer and load branch_target.
REQ-010 branch_target  in  ADDR_W  absolute redirect address.
REQ-011 mem_req  out  1  memory request valid.
REQ-012 mem_address  out  ADDR_W  request address; stable while mem_req=1 and mem_gnt=0, except on redirect (REQ-024).
REQ-013 mem_gnt  in  1  memory accepts the request in this cycle.
REQ-014 mem_rvalid  in  1  read data valid; in order; at least 1 cycle after grant.
REQ-015 mem_read_data  in  INSTR_W  returned instruction word.
REQ-016 instr_valid  out  1  buffer head valid.
REQ-017 instr_ready  in  1  downstream accepts the head when instr_valid=1.
REQ-018 instruction  out  INSTR_W  buffer head word.
REQ-019 instr_pc  out  ADDR_W  fetch address of the buffer head.

Function
REQ-020 FSM states: IDLE (no request), REQ (mem_req=1), WAIT (granted, awaiting mem_rvalid); only one request is outstanding at a time.
REQ-021 IDLE->REQ when halt=0 and count<DEPTH; otherwise remain in IDLE.
REQ-022 REQ->WAIT on mem_gnt=1; pc <= pc+PC_STEP mod 2^ADDR_W; granted address latched as the tag for the response.
REQ-023 WAIT on mem_rvalid=1: push {data, tag} unless discard=1; next state is REQ if halt=0 and post-push count<DEPTH, else IDLE; discard cleared.
REQ-024 Branch in any state: buffer emptied; pc <= branch_target. In REQ without mem_gnt: stay in REQ; mem_address = branch_target next cycle. In REQ with mem_gnt or in WAIT: discard <= 1 and the in-flight response is dropped. A mem_rvalid arriving in the branch cycle is dropped.
REQ-025 Branch has priority over every other same-cycle event; an instr_ready handshake in the branch cycle has no effect on the flushed buffer.
REQ-026 Halt does not cancel a granted request; its response is buffered normally; an ungranted REQ is held until grant.
REQ-027 Buffer is a FIFO of DEPTH entries; pop when instr_valid & instr_ready; push and pop in the same cycle leave count unchanged.
REQ-028 Space is reserved before issue, so a push never occurs while full; instr_valid = (count != 0).
REQ-029 Latency: rvalid at edge N -> instr_valid=1 after edge N+1 when the buffer was empty.
REQ-030 mem_address = pc; instruction/instr_pc come from the head entry, 0 when empty.

Reset
REQ-031 rst=0 sampled at a rising edge: pc=RESET_PC, state=IDLE, discard=0, count=0, mem_req=0, instr_valid=0, instruction=0, instr_pc=0.
REQ-032 Reset mid-transaction abandons any outstanding request; a mem_rvalid arriving after reset release while in IDLE/REQ is ignored.
REQ-033 With halt=0, mem_req=1 with mem_address=RESET_PC no later than the 2nd rising edge after rst returns to 1.

Verification
REQ-034 Defaults, mem_gnt=1 each cycle, rvalid 1 cycle after grant, instr_ready=1 -> instr_pc sequence 0x00,0x04,0x08,... with matching data; wrap 0xFC->0x00.
REQ-035 instr_ready=0 -> exactly 4 words buffered, mem_req stays 0 while count=4; one pop -> one new request at the next address.
REQ-036 Branch to 0x40 while in WAIT; response arrives 3 cycles later -> response dropped, buffer empty, next request address 0x40.
REQ-037 Branch to 0x80 while in REQ with mem_gnt=0 -> mem_address=0x80 next cycle, mem_req stays 1, no data lost or duplicated.
REQ-038 halt=1 asserted in WAIT -> response buffered, no further mem_req until halt=0; pc unchanged during halt.
REQ-039 rst=0 for 1 cycle while in WAIT, then stray mem_rvalid -> no push, instr_valid=0, restart at RESET_PC.
